seven_seg_reader: RTL and testbench

Reads back a multiplexed, active-low seven-segment display bus (segment lines plus active-low digit selects) and reconstructs the value shown on each digit. It is the receiving end of the count-to-segment encoding path. It sits beside the display driver as a self-check and monitor, so logic or a bench can confirm what the panel is actually showing. Each digit's pattern must hold stable for a programmable number of consecutive cycles before it is accepted.

---
 rtl/seven_seg_reader_pkg.sv | 35 +++
 rtl/seven_seg_reader_decode.sv | 39 +++
 rtl/seven_seg_reader.sv | 137 +++++++++++++
 tb/tb_seven_seg_reader.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_reader_pkg.sv
// Shared definitions for the seven-segment read-back path: segment patterns,
// FSM state encoding and decode-result classes. Hex patterns matter only with SEVEN_SEG_HEX_EN.
package seven_seg_reader_pkg;

  // Active-low patterns, bit 6 = g ... bit 0 = a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_TRACK  = 2'd1;
  localparam state_t ST_LOCKED = 2'd2;

  typedef enum logic [1:0] {
    CLS_VALUE   = 2'd0,
    CLS_BLANK   = 2'd1,
    CLS_INVALID = 2'd2
  } seg_class_t;

endpackage

// File: rtl/seven_seg_reader_decode.sv
// Combinational segment-pattern lookup; hex letters decode only when
// SEVEN_SEG_HEX_EN is defined, otherwise they fall into the invalid class.
module seven_seg_decode
  import seven_seg_reader_pkg::*;
(
  input  logic [6:0]  seg,
  output seg_class_t  cls,
  output logic [3:0]  value
);

  // Pattern to {class, value} lookup
  always_comb begin
    cls   = CLS_VALUE;
    value = 4'd0;
    case (seg)
      SEG_0: value = 4'd0;
      SEG_1: value = 4'd1;
      SEG_2: value = 4'd2;
      SEG_3: value = 4'd3;
      SEG_4: value = 4'd4;
      SEG_5: value = 4'd5;
      SEG_6: value = 4'd6;
      SEG_7: value = 4'd7;
      SEG_8: value = 4'd8;
      SEG_9: value = 4'd9;
`ifdef SEVEN_SEG_HEX_EN
      SEG_A: value = 4'd10;
      SEG_B: value = 4'd11;
      SEG_C: value = 4'd12;
      SEG_D: value = 4'd13;
      SEG_E: value = 4'd14;
      SEG_F: value = 4'd15;
`endif
      SEG_BLANK: cls = CLS_BLANK;
      default:   cls = CLS_INVALID;
    endcase
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Monitors a multiplexed active-low seven-segment bus and commits each digit's
// value once its pattern has been stable for STABLE samples. Option: SEVEN_SEG_HEX_EN.
module seven_seg_reader
  import seven_seg_reader_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int STABLE = 3
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [6:0]                                  seg,
  input  logic [DIGITS-1:0]                           an,
  output logic [4*DIGITS-1:0]                         digits,
  output logic [DIGITS-1:0]                           valid,
  output logic [DIGITS-1:0]                           err,
  output logic                                        upd,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] upd_idx
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE);

  logic [DIGITS-1:0] sel_s;
  logic              onehot_s;
  logic [IW-1:0]     idx_s;
  logic              same_s;
  seg_class_t        cls_s;
  logic [3:0]        value_s;

  state_t            state_r, state_nxt_s;
  logic [CW-1:0]     cnt_r, cnt_nxt_s;
  logic [IW-1:0]     last_idx_r;
  logic [6:0]        last_seg_r;
  logic              commit_s;

  logic [4*DIGITS-1:0] digits_r;
  logic [DIGITS-1:0]   valid_r, err_r;
  logic                upd_r;
  logic [IW-1:0]       upd_idx_r;

  seven_seg_decode u_decode (
    .seg   (seg),
    .cls   (cls_s),
    .value (value_s)
  );

  assign sel_s    = ~an;
  assign onehot_s = (sel_s != '0) && ((sel_s & (sel_s - DIGITS'(1))) == '0);
  assign same_s   = (idx_s == last_idx_r) && (seg == last_seg_r);

  // Encode the low select line into a digit index
  always_comb begin
    idx_s = '0;
    for (int k = 0; k < DIGITS; k++) begin
      idx_s = an[k] ? idx_s : IW'(k);
    end
  end

  // Run counter and state sequencing; a commit fires the cycle the run reaches STABLE
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    commit_s    = 1'b0;
    if (!onehot_s) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = '0;
    end else if ((state_r == ST_IDLE) || !same_s) begin
      cnt_nxt_s   = CW'(1);
      commit_s    = (STABLE_C == CW'(1));
      state_nxt_s = commit_s ? ST_LOCKED : ST_TRACK;
    end else if (state_r == ST_LOCKED) begin
      state_nxt_s = ST_LOCKED;
    end else begin
      cnt_nxt_s   = (cnt_r < STABLE_C) ? (cnt_r + CW'(1)) : cnt_r;
      commit_s    = (cnt_nxt_s == STABLE_C);
      state_nxt_s = commit_s ? ST_LOCKED : ST_TRACK;
    end
  end

  // Tracker and FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      last_idx_r <= '0;
      last_seg_r <= 7'd0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      last_idx_r <= onehot_s ? idx_s : last_idx_r;
      last_seg_r <= onehot_s ? seg : last_seg_r;
    end
  end

  // Per-digit committed state and the commit pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_r  <= '0;
      valid_r   <= '0;
      err_r     <= '0;
      upd_r     <= 1'b0;
      upd_idx_r <= '0;
    end else begin
      upd_r <= commit_s;
      if (commit_s) begin
        upd_idx_r <= idx_s;
      end
      for (int k = 0; k < DIGITS; k++) begin
        if (commit_s && (idx_s == IW'(k))) begin
          case (cls_s)
            CLS_VALUE: begin
              digits_r[4*k +: 4] <= value_s;
              valid_r[k]         <= 1'b1;
              err_r[k]           <= 1'b0;
            end
            CLS_BLANK: begin
              valid_r[k] <= 1'b0;
              err_r[k]   <= 1'b0;
            end
            default: begin
              valid_r[k] <= 1'b0;
              err_r[k]   <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign digits  = digits_r;
  assign valid   = valid_r;
  assign err     = err_r;
  assign upd     = upd_r;
  assign upd_idx = upd_idx_r;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Self-checking bench for seven_seg_reader (DIGITS=4, STABLE=3): directed table
// plus randomized runs against a run-length reference model.
module tb_seven_seg_reader;

  localparam int DIGITS = 4;
  localparam int STABLE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  valid, err;
  logic        upd;
  logic [1:0]  upd_idx;

  int n_pass = 0;
  int n_total = 0;

  seven_seg_reader #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an),
    .digits(digits), .valid(valid), .err(err), .upd(upd), .upd_idx(upd_idx)
  );

  always #5 clk = ~clk;

  // Reference decode: table search over the sixteen glyphs
  logic [6:0] glyph [16];
  initial begin
    glyph[0] = 7'b1000000;  glyph[1] = 7'b1111001;  glyph[2] = 7'b0100100;
    glyph[3] = 7'b0110000;  glyph[4] = 7'b0011001;  glyph[5] = 7'b0010010;
    glyph[6] = 7'b0000010;  glyph[7] = 7'b1111000;  glyph[8] = 7'b0000000;
    glyph[9] = 7'b0010000;  glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
    glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110;
    glyph[15] = 7'b0001110;
  end

`ifdef SEVEN_SEG_HEX_EN
  localparam int NGLYPH = 16;
`else
  localparam int NGLYPH = 10;
`endif

  // Model state: committed outputs plus length of the current identical run
  logic [15:0] m_dig;
  logic [3:0]  m_valid, m_err;
  logic        m_upd;
  logic [1:0]  m_idx;
  int          run_len;
  logic [3:0]  prev_an;
  logic [6:0]  prev_seg;

  task automatic model_update(input logic r, input logic [3:0] a, input logic [6:0] s);
    int k;
    int val;
    if (r) begin
      m_dig = 16'h0; m_valid = 4'h0; m_err = 4'h0; m_upd = 1'b0; m_idx = 2'd0;
      run_len = 0;
    end else begin
      if ($countones(~a) != 1) begin
        run_len = 0;
      end else if (run_len > 0 && a == prev_an && s == prev_seg) begin
        run_len = (run_len < 1000) ? run_len + 1 : run_len;
      end else begin
        run_len = 1;
      end
      m_upd = (run_len == STABLE);
      if (m_upd) begin
        k = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) k = i;
        m_idx = 2'(k);
        val = -1;
        for (int g = 0; g < NGLYPH; g++) if (glyph[g] == s) val = g;
        if (val >= 0) begin
          m_dig[4*k +: 4] = 4'(val); m_valid[k] = 1'b1; m_err[k] = 1'b0;
        end else if (s == 7'b1111111) begin
          m_valid[k] = 1'b0; m_err[k] = 1'b0;
        end else begin
          m_valid[k] = 1'b0; m_err[k] = 1'b1;
        end
      end
    end
    prev_an = a;
    prev_seg = s;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic [3:0] a, input logic [6:0] s);
    rst = r; an = a; seg = s;
    @(posedge clk);
    model_update(r, a, s);
    #1;
    check("model_digits", 32'(digits), 32'(m_dig));
    check("model_valid", 32'(valid), 32'(m_valid));
    check("model_err", 32'(err), 32'(m_err));
    check("model_upd", 32'(upd), 32'(m_upd));
    if (m_upd) check("model_upd_idx", 32'(upd_idx), 32'(m_idx));
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        upd;
    logic [1:0]  idx;
    logic [3:0]  valid;
    logic [3:0]  err;
    logic [15:0] dig;
  } vec_t;

  vec_t vq[$];
  logic [1:0]  c_idx;
  logic [3:0]  c_valid, c_err;
  logic [15:0] c_dig;

  // n cycles of one input; only the last cycle may carry a commit with new outputs
  task automatic add(input logic r, input logic [3:0] a, input logic [6:0] s, input int n,
                     input logic u, input logic [1:0] i, input logic [3:0] v,
                     input logic [3:0] e, input logic [15:0] d);
    for (int j = 0; j < n - 1; j++) vq.push_back('{r, a, s, 1'b0, c_idx, c_valid, c_err, c_dig});
    if (u || r) c_idx = i;
    c_valid = v; c_err = e; c_dig = d;
    vq.push_back('{r, a, s, u, c_idx, c_valid, c_err, c_dig});
  endtask

  initial begin
    logic [3:0] ra;
    logic [6:0] rs;
    logic       rr;
    c_idx = 2'd0; c_valid = 4'h0; c_err = 4'h0; c_dig = 16'h0;
    rst = 1'b1; an = 4'hF; seg = 7'h7F;
    m_dig = 16'h0; m_valid = 4'h0; m_err = 4'h0; m_upd = 1'b0; m_idx = 2'd0;
    run_len = 0; prev_an = 4'hF; prev_seg = 7'h7F;

    add(1'b1, 4'hF, 7'b1111111, 2, 1'b0, 2'd0, 4'h0, 4'h0, 16'h0000);
    add(1'b0, 4'b1110, 7'b0100100, 3, 1'b1, 2'd0, 4'h1, 4'h0, 16'h0002);
    add(1'b0, 4'b1110, 7'b0100100, 4, 1'b0, 2'd0, 4'h1, 4'h0, 16'h0002);
    add(1'b0, 4'b1101, 7'b0110000, 2, 1'b0, 2'd0, 4'h1, 4'h0, 16'h0002);
    add(1'b0, 4'b1101, 7'b0000000, 1, 1'b0, 2'd0, 4'h1, 4'h0, 16'h0002);
    add(1'b0, 4'b1101, 7'b0110000, 3, 1'b1, 2'd1, 4'h3, 4'h0, 16'h0032);
    add(1'b0, 4'b1011, 7'b1010101, 3, 1'b1, 2'd2, 4'h3, 4'h4, 16'h0032);
    add(1'b0, 4'b1111, 7'b0011001, 5, 1'b0, 2'd0, 4'h3, 4'h4, 16'h0032);
    add(1'b0, 4'b1100, 7'b0011001, 5, 1'b0, 2'd0, 4'h3, 4'h4, 16'h0032);
    add(1'b0, 4'b0111, 7'b1111111, 3, 1'b1, 2'd3, 4'h3, 4'h4, 16'h0032);
`ifdef SEVEN_SEG_HEX_EN
    add(1'b0, 4'b1110, 7'b0001000, 3, 1'b1, 2'd0, 4'h3, 4'h4, 16'h003A);
`else
    add(1'b0, 4'b1110, 7'b0001000, 3, 1'b1, 2'd0, 4'h2, 4'h5, 16'h0032);
`endif
    add(1'b0, 4'b1101, 7'b1111001, 2, 1'b0, 2'd0, c_valid, c_err, c_dig);
    add(1'b1, 4'b1101, 7'b1111001, 1, 1'b0, 2'd0, 4'h0, 4'h0, 16'h0000);
    add(1'b0, 4'b1101, 7'b1111001, 2, 1'b0, 2'd0, 4'h0, 4'h0, 16'h0000);
    add(1'b0, 4'b1101, 7'b1111001, 1, 1'b1, 2'd1, 4'h2, 4'h0, 16'h0010);
    add(1'b0, 4'b1110, 7'b0100100, 3, 1'b1, 2'd0, 4'h3, 4'h0, 16'h0012);
    add(1'b0, 4'b1101, 7'b1111001, 3, 1'b1, 2'd1, 4'h3, 4'h0, 16'h0012);
    add(1'b0, 4'b1101, 7'b1111001, 6, 1'b0, 2'd1, 4'h3, 4'h0, 16'h0012);

    foreach (vq[n]) begin
      step(vq[n].rst, vq[n].an, vq[n].seg);
      check("tbl_digits", 32'(digits), 32'(vq[n].dig));
      check("tbl_valid", 32'(valid), 32'(vq[n].valid));
      check("tbl_err", 32'(err), 32'(vq[n].err));
      check("tbl_upd", 32'(upd), 32'(vq[n].upd));
      check("tbl_upd_idx", 32'(upd_idx), 32'(vq[n].idx));
    end

    ra = 4'b1110; rs = 7'b1000000;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(99) < 35) begin
        case ($urandom_range(5))
          0:       ra = 4'hF;
          1:       ra = 4'($urandom);
          default: ra = ~(4'b0001 << $urandom_range(3));
        endcase
        case ($urandom_range(4))
          0:       rs = 7'b1111111;
          1:       rs = 7'($urandom);
          default: rs = glyph[$urandom_range(15)];
        endcase
      end
      rr = ($urandom_range(99) == 0);
      step(rr, ra, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
